alu_result_checker: RTL and testbench

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_result_checker.sv | 149 ++++++++++++++
 tb/tb_alu_result_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - checks a stream of ALU result vectors against a reference ALU
// Vectors are registered into one stage, compared, and tallied one cycle after vld.
module alu_result_checker #(
   parameter int MAX_CNT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       vld,
   input  logic       last,
   input  logic [6:0] A,
   input  logic [6:0] B,
   input  logic [1:0] OP,
   input  logic [6:0] R,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] pass_cnt,
   output logic [7:0] fail_cnt,
   output logic [7:0] first_fail_idx,
   output logic [6:0] first_fail_exp
);

   localparam logic [7:0] CNT_MAX  = 8'(MAX_CNT);
   localparam logic [7:0] IDX_NONE = 8'hFF;
   localparam logic [7:0] IDX_SAT  = 8'hFE;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic       s1_vld;
   logic       s1_last;
   logic [6:0] s1_a;
   logic [6:0] s1_b;
   logic [1:0] s1_op;
   logic [6:0] s1_r;
   logic [7:0] s1_idx;
   logic [7:0] vec_idx;

   logic [6:0] exp_r;
   logic       accept;
   logic       retire;
   logic       mismatch;

   function automatic logic [6:0] ref_alu(input logic [6:0] a, input logic [6:0] b,
                                          input logic [1:0] op);
      logic [6:0] res;
      case (op)
         2'b00:   res = a + b;
         2'b01:   res = a - b;
         2'b10:   res = ~(a & b);
         default: res = {a[5:0], a[6]};
      endcase
      return res;
   endfunction

   // A vector sampled with last blocks acceptance until the run retires it.
   always_comb begin
      accept   = (state == S_RUN) && vld && !start && !(s1_vld && s1_last);
      retire   = (state == S_RUN) && s1_vld && !start;
      exp_r    = ref_alu(s1_a, s1_b, s1_op);
      mismatch = (exp_r != s1_r);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (start)                  state_nxt = S_RUN;
            else if (retire && s1_last) state_nxt = S_DONE;
         end
         S_DONE: begin
            if (start) state_nxt = S_RUN;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_last <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_op   <= '0;
         s1_r    <= '0;
         s1_idx  <= '0;
         vec_idx <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_last <= last;
            s1_a    <= A;
            s1_b    <= B;
            s1_op   <= OP;
            s1_r    <= R;
            s1_idx  <= vec_idx;
            if (vec_idx != IDX_SAT) vec_idx <= vec_idx + 8'd1;
         end else if (start) begin
            vec_idx <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         err            <= 1'b0;
         first_fail_idx <= IDX_NONE;
         first_fail_exp <= '0;
      end else if (start) begin
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         err            <= 1'b0;
         first_fail_idx <= IDX_NONE;
         first_fail_exp <= '0;
      end else if (retire) begin
         if (!mismatch) begin
            if (pass_cnt < CNT_MAX) pass_cnt <= pass_cnt + 8'd1;
         end else begin
            if (fail_cnt < CNT_MAX) fail_cnt <= fail_cnt + 8'd1;
            err <= 1'b1;
            if (first_fail_idx == IDX_NONE) begin
               first_fail_idx <= s1_idx;
               first_fail_exp <= exp_r;
            end
         end
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - scoreboard bench for alu_result_checker
module tb_alu_result_checker;

   localparam int MAX = 255;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       vld;
   logic       last;
   logic [6:0] a;
   logic [6:0] b;
   logic [1:0] op;
   logic [6:0] r;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;
   logic [7:0] first_fail_idx;
   logic [6:0] first_fail_exp;

   always #5 clk = ~clk;

   alu_result_checker #(.MAX_CNT(MAX)) dut (
      .clk(clk), .rst(rst), .start(start), .vld(vld), .last(last),
      .A(a), .B(b), .OP(op), .R(r),
      .busy(busy), .done(done), .err(err),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp)
   );

   typedef struct {
      int pass;
      int fail;
      int err;
      int idx;
      int fexp;
   } res_t;

   res_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_pass, m_fail, m_err, m_idx, m_fexp, m_vec;
   int   gap_pct = 0;

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, expv);
      end
   endtask

   function automatic int ref_alu(input int x, input int y, input int o);
      case (o)
         0:       return (x + y) % 128;
         1:       return (x - y + 128) % 128;
         2:       return 127 - (x & y);
         default: return (x * 2) % 128 + x / 64;
      endcase
   endfunction

   task automatic cyc(input logic st, input logic v, input int ai, input int bi,
                      input int oi, input int ri, input logic l);
      @(negedge clk);
      start = st;
      vld   = v;
      a     = ai[6:0];
      b     = bi[6:0];
      op    = oi[1:0];
      r     = ri[6:0];
      last  = l;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
   endtask

   task automatic begin_run();
      cyc(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
      m_pass = 0; m_fail = 0; m_err = 0; m_idx = 255; m_fexp = 0; m_vec = 0;
   endtask

   task automatic send_vec(input int ai, input int bi, input int oi, input int ri,
                           input logic l);
      int e;
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle();
      cyc(1'b0, 1'b1, ai, bi, oi, ri, l);
      e = ref_alu(ai, bi, oi);
      if (ri == e) begin
         if (m_pass < MAX) m_pass++;
      end else begin
         if (m_fail < MAX) m_fail++;
         if (m_err == 0) begin
            m_err  = 1;
            m_idx  = (m_vec < 254) ? m_vec : 254;
            m_fexp = e;
         end
      end
      m_vec++;
   endtask

   // Pushes the run expectation and drives one stray vld right after last.
   task automatic close_run();
      res_t x;
      x.pass = m_pass; x.fail = m_fail; x.err = m_err; x.idx = m_idx; x.fexp = m_fexp;
      exp_q.push_back(x);
      cyc(1'b0, 1'b1, int'($urandom), int'($urandom), int'($urandom), int'($urandom),
          1'($urandom_range(1)));
   endtask

   task automatic wait_done();
      for (int i = 0; i < 8 && !done; i++) idle();
      chk("done_seen", int'(done), 1);
   endtask

   task automatic rand_run(input int n, input int fail_pct, input logic [15:0] fmask);
      int  ai, bi, oi, e, ri;
      bit  bad;
      begin_run();
      for (int i = 0; i < n; i++) begin
         ai  = int'($urandom_range(127));
         bi  = int'($urandom_range(127));
         oi  = int'($urandom_range(3));
         e   = ref_alu(ai, bi, oi);
         bad = (i < 16 && fmask[i]) || (int'($urandom_range(99)) < fail_pct);
         ri  = bad ? (e ^ int'($urandom_range(1, 127))) : e;
         send_vec(ai, bi, oi, ri, i == n - 1);
      end
      close_run();
      wait_done();
   endtask

   initial begin : monitor
      res_t e;
      logic prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: got done with no run pending, required none");
            end else begin
               e = exp_q.pop_front();
               chk("sb_pass_cnt", int'(pass_cnt), e.pass);
               chk("sb_fail_cnt", int'(fail_cnt), e.fail);
               chk("sb_err", int'(err), e.err);
               chk("sb_first_fail_idx", int'(first_fail_idx), e.idx);
               chk("sb_first_fail_exp", int'(first_fail_exp), e.fexp);
               chk("sb_busy_in_done", int'(busy), 0);
            end
         end
         prev_done = done;
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1'b1; start = 1'b0; vld = 1'b0; last = 1'b0;
      a = '0; b = '0; op = '0; r = '0;
      repeat (3) idle();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_pass", int'(pass_cnt), 0);
      chk("rst_fail", int'(fail_cnt), 0);
      chk("rst_idx", int'(first_fail_idx), 255);
      chk("rst_exp", int'(first_fail_exp), 0);
      @(negedge clk); rst = 1'b0;

      // vld in IDLE is ignored
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1, 2, 0, 9, 1'b0);
      idle(); idle();
      chk("idle_vld_pass", int'(pass_cnt), 0);
      chk("idle_vld_fail", int'(fail_cnt), 0);
      chk("idle_vld_busy", int'(busy), 0);

      // four good vectors, with one-cycle latency checks
      begin_run();
      send_vec(100, 50, 0, 22, 1'b0);
      send_vec(5, 9, 1, 124, 1'b0);
      chk("latency_before", int'(pass_cnt), 0);
      chk("run_busy", int'(busy), 1);
      send_vec(127, 15, 2, 112, 1'b0);
      chk("latency_after", int'(pass_cnt), 1);
      send_vec(65, 0, 3, 3, 1'b1);
      close_run();
      wait_done();

      // one failure at index 1; err rises with fail_cnt
      begin_run();
      send_vec(10, 20, 0, 30, 1'b0);
      send_vec(100, 50, 0, 23, 1'b0);
      send_vec(3, 4, 0, 7, 1'b0);
      chk("err_pre_fail", int'(fail_cnt), 0);
      chk("err_pre_err", int'(err), 0);
      send_vec(1, 1, 1, 0, 1'b1);
      chk("err_same_fail", int'(fail_cnt), 1);
      chk("err_same_err", int'(err), 1);
      close_run();
      wait_done();

      rand_run(7, 0, 16'b0000_0000_0010_0100);
      rand_run(300, 0, 16'h0000);

      // reset the cycle after a failing vld
      begin_run();
      send_vec(1, 1, 0, 2, 1'b0);
      send_vec(100, 50, 0, 23, 1'b0);
      cyc(1'b0, 1'b1, 3, 3, 0, 6, 1'b0);
      rst = 1'b1;
      idle();
      chk("midrst_fail", int'(fail_cnt), 0);
      chk("midrst_err", int'(err), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_idx", int'(first_fail_idx), 255);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1, 1, 0, 5, 1'b0);
      idle();
      chk("postrst_fail", int'(fail_cnt), 0);
      chk("postrst_pass", int'(pass_cnt), 0);
      chk("postrst_busy", int'(busy), 0);

      // start in DONE after a failing run
      rand_run(5, 0, 16'h0001);
      begin_run();
      idle();
      chk("redo_pass", int'(pass_cnt), 0);
      chk("redo_fail", int'(fail_cnt), 0);
      chk("redo_err", int'(err), 0);
      chk("redo_idx", int'(first_fail_idx), 255);
      chk("redo_busy", int'(busy), 1);
      send_vec(2, 3, 0, 5, 1'b1);
      close_run();
      wait_done();

      // start in RUN discards the vector in flight
      begin_run();
      send_vec(100, 50, 0, 0, 1'b0);
      begin_run();
      send_vec(7, 7, 1, 0, 1'b0);
      send_vec(96, 1, 3, 65, 1'b1);
      close_run();
      wait_done();

      gap_pct = 30;
      for (int k = 0; k < 25; k++) rand_run(int'($urandom_range(1, 12)), 30, 16'h0000);
      gap_pct = 0;

      repeat (3) idle();
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
